effect_param_controller: RTL

Generalised user-parameter controller for the audio effect chain. Holds NUM_PARAMS saturating parameter registers (echo time, echo volume, and later effect parameters), adjusted by two active-low push-buttons. Buttons are debounced, with auto-repeat while held. A one-hot switch bank selects the parameter being edited. Each parameter also drives a registered, scaled output that feeds the effect datapath.

---
 rtl/effect_param_controller.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/effect_param_controller.sv
// Debounced two-button editor for NUM_PARAMS saturating effect parameters,
// with auto-repeat and a registered scaled copy of each parameter.
module effect_param_controller #(
    parameter int NUM_PARAMS      = 2,
    parameter int PARAM_WIDTH     = 8,
    parameter int INIT_VALUE      = 64,
    parameter int MIN_VALUE       = 4,
    parameter int MAX_VALUE       = 128,
    parameter int STEP            = 4,
    parameter int OUT_WIDTH       = 32,
    parameter int SCALE_MUL       = 65535,
    parameter int SCALE_SHIFT     = 7,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              key_dec,
    input  logic                              key_inc,
    input  logic [NUM_PARAMS-1:0]             sel,
    input  logic                              enable_sw,
    output logic [NUM_PARAMS*PARAM_WIDTH-1:0] param_raw,
    output logic [NUM_PARAMS*OUT_WIDTH-1:0]   param_scaled,
    output logic [NUM_PARAMS-1:0]             changed,
    output logic                              disabled
);

    localparam int PW  = PARAM_WIDTH;
    localparam int MW  = $clog2(SCALE_MUL + 1);
    localparam int PRW = PW + MW;
    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 2);
    localparam int RMX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW = $clog2(RMX + 1);

    localparam logic [PW:0] STEP_X = (PW+1)'(STEP);
    localparam logic [PW:0] MIN_X  = (PW+1)'(MIN_VALUE);
    localparam logic [PW:0] MAX_X  = (PW+1)'(MAX_VALUE);

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_HOLD,
        RS_REPEAT
    } rpt_state_t;

    function automatic logic [OUT_WIDTH-1:0] scale(input logic [PW-1:0] v);
        logic [PRW-1:0] p;
        p = PRW'(v) * PRW'(SCALE_MUL);
        return OUT_WIDTH'(p >> SCALE_SHIFT);
    endfunction

    function automatic logic [PW-1:0] step_up(input logic [PW-1:0] v);
        logic [PW:0] s;
        s = {1'b0, v} + STEP_X;
        return (s > MAX_X) ? MAX_X[PW-1:0] : s[PW-1:0];
    endfunction

    function automatic logic [PW-1:0] step_down(input logic [PW-1:0] v);
        logic [PW:0] s;
        s = {1'b0, v} - STEP_X;
        return ({1'b0, v} < MIN_X + STEP_X) ? MIN_X[PW-1:0] : s[PW-1:0];
    endfunction

    logic [1:0] key_n;
    logic [1:0] key_ev;

    assign key_n = {key_inc, key_dec};

    for (genvar k = 0; k < 2; k++) begin : g_key
        logic           s1, s2;
        logic           deb, deb_q;
        logic           lock;
        logic [DCW-1:0] dcnt, rcnt;
        rpt_state_t     st, st_n;
        logic [RCW-1:0] cnt, cnt_n;
        logic           ev;

        // lock ignores a key that was already held when reset released
        always_ff @(posedge CLK) begin
            if (RST) begin
                s1    <= 1'b1;
                s2    <= 1'b1;
                deb   <= 1'b1;
                deb_q <= 1'b1;
                dcnt  <= '0;
                lock  <= 1'b1;
                rcnt  <= '0;
            end else begin
                s1    <= key_n[k];
                s2    <= s1;
                deb_q <= deb;
                if (s2 != deb) begin
                    if (dcnt == DCW'(DEBOUNCE_CYCLES - 1)) begin
                        deb  <= s2;
                        dcnt <= '0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end else begin
                    dcnt <= '0;
                end
                if (lock) begin
                    if (s2 && deb) begin
                        if (rcnt == DCW'(DEBOUNCE_CYCLES + 1))
                            lock <= 1'b0;
                        else
                            rcnt <= rcnt + 1'b1;
                    end else begin
                        rcnt <= '0;
                    end
                end
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                st  <= RS_IDLE;
                cnt <= '0;
            end else begin
                st  <= st_n;
                cnt <= cnt_n;
            end
        end

        always_comb begin
            st_n  = st;
            cnt_n = '0;
            ev    = 1'b0;
            if (deb) begin
                st_n = RS_IDLE;
            end else begin
                unique case (st)
                    RS_IDLE: begin
                        if (deb_q && !lock) begin
                            ev   = 1'b1;
                            st_n = RS_HOLD;
                        end
                    end
                    RS_HOLD: begin
                        if (cnt == RCW'(REPEAT_DELAY - 1)) begin
                            ev   = 1'b1;
                            st_n = RS_REPEAT;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                    RS_REPEAT: begin
                        if (cnt == RCW'(REPEAT_PERIOD - 1))
                            ev = 1'b1;
                        else
                            cnt_n = cnt + 1'b1;
                    end
                    default: st_n = RS_IDLE;
                endcase
            end
        end

        assign key_ev[k] = ev;
    end

    logic [NUM_PARAMS-1:0] tgt;
    logic                  do_inc, do_dec;
    logic [PW-1:0]         raw    [NUM_PARAMS];
    logic [PW-1:0]         raw_n  [NUM_PARAMS];
    logic [OUT_WIDTH-1:0]  scaled [NUM_PARAMS];

    assign tgt    = sel & (~sel + NUM_PARAMS'(1));
    assign do_inc = key_ev[1] & ~key_ev[0];
    assign do_dec = key_ev[0] & ~key_ev[1];

    always_comb begin
        for (int i = 0; i < NUM_PARAMS; i++) begin
            raw_n[i] = raw[i];
            if (tgt[i] && do_inc)
                raw_n[i] = step_up(raw[i]);
            else if (tgt[i] && do_dec)
                raw_n[i] = step_down(raw[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                raw[i]    <= PW'(INIT_VALUE);
                scaled[i] <= scale(PW'(INIT_VALUE));
            end
            changed  <= '0;
            disabled <= 1'b1;
        end else begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                raw[i]     <= raw_n[i];
                changed[i] <= (raw_n[i] != raw[i]);
                scaled[i]  <= scale(raw[i]);
            end
            disabled <= ~enable_sw;
        end
    end

    for (genvar i = 0; i < NUM_PARAMS; i++) begin : g_out
        assign param_raw[i*PW +: PW]               = raw[i];
        assign param_scaled[i*OUT_WIDTH +: OUT_WIDTH] = scaled[i];
    end

endmodule
